mem_arbiter: RTL

- Shares one unified instruction/data memory between NREQ multicycle cores in the multiprocessor.
- Each core's memory-access state (fetch, load, store) raises a request and stalls until the arbiter grants it.
- The arbiter serialises accesses with round-robin fairness and returns read data with a one-cycle grant pulse.
- It sits between the per-core controller/datapath pairs and the single-port synchronous memory.

---
 rtl/arb_pkg.sv | 13 +
 rtl/mem_arbiter_if.sv | 30 +++
 rtl/mem_arbiter_rr_picker.sv | 34 +++
 rtl/mem_arbiter.sv | 114 +++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
package arb_pkg;

    localparam int NREQ_DEF = 2;
    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side request bus plus the single-port memory bus of the arbiter.
// Handshake: a core raises req[i] with we/adr/wdata stable and holds them until
// its one-cycle gnt[i] pulse; gnt marks completion and rdata is valid only then.
interface mem_arbiter_if #(
    parameter int NREQ = 2,
    parameter int XLEN = 32
) ();

    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      we;
    logic [NREQ*XLEN-1:0] adr;
    logic [NREQ*XLEN-1:0] wdata;
    logic [NREQ-1:0]      gnt;
    logic [XLEN-1:0]      rdata;
    logic [XLEN-1:0]      mem_adr;
    logic [XLEN-1:0]      mem_wd;
    logic                 mem_we;
    logic [XLEN-1:0]      mem_rd;

    modport slave (
        input  req, we, adr, wdata, mem_rd,
        output gnt, rdata, mem_adr, mem_wd, mem_we
    );

    modport master (
        output req, we, adr, wdata, mem_rd,
        input  gnt, rdata, mem_adr, mem_wd, mem_we
    );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin priority: first unmasked request at or after ptr, with wrap.
module rr_picker #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [NREQ-1:0] mask_i,
    input  logic [PW-1:0]   ptr_i,
    output logic            valid_o,
    output logic [PW-1:0]   winner_o
);

    localparam int SW = PW + 1;

    logic [NREQ-1:0] cand;
    assign cand = req_i & ~mask_i;

    // Scan from the farthest offset down so the nearest candidate to ptr wins last.
    always_comb begin
        logic [SW-1:0] sum;
        sum      = '0;
        valid_o  = 1'b0;
        winner_o = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            sum = {1'b0, ptr_i} + SW'(off);
            if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
            if (cand[sum[PW-1:0]]) begin
                valid_o  = 1'b1;
                winner_o = sum[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising NREQ cores onto one single-port synchronous memory.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int XLEN = XLEN_DEF,
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus,
    output arb_state_t    state_o,
    output logic [PW-1:0] ptr_o
);

    arb_state_t      state_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   owner_q;
    logic [XLEN-1:0] adr_q;
    logic [XLEN-1:0] wdata_q;
    logic            mem_we_q;
    logic [NREQ-1:0] gnt_q;

    logic [NREQ-1:0] pick_mask;
    logic [PW-1:0]   pick_ptr;
    logic [PW-1:0]   pick_idx;
    logic            pick_valid;
    logic            capture;
    logic [XLEN-1:0] pick_adr;
    logic [XLEN-1:0] pick_wdata;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + PW'(1);
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
        return NREQ'(1) << i;
    endfunction

    // In DONE the owner's req is still high, so it is masked and the scan starts past it.
    always_comb begin
        pick_mask = '0;
        pick_ptr  = ptr_q;
        if (state_q == DONE) begin
            pick_mask = onehot(owner_q);
            pick_ptr  = next_idx(owner_q);
        end
    end

    rr_picker #(.NREQ(NREQ), .PW(PW)) u_picker (
        .req_i    (bus.req),
        .mask_i   (pick_mask),
        .ptr_i    (pick_ptr),
        .valid_o  (pick_valid),
        .winner_o (pick_idx)
    );

    always_comb begin
        pick_adr   = '0;
        pick_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (PW'(i) == pick_idx) begin
                pick_adr   = bus.adr[i*XLEN +: XLEN];
                pick_wdata = bus.wdata[i*XLEN +: XLEN];
            end
        end
    end

    assign capture = pick_valid && (state_q != ISSUE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            adr_q    <= '0;
            wdata_q  <= '0;
            mem_we_q <= 1'b0;
            gnt_q    <= '0;
        end else begin
            gnt_q    <= '0;
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE:  state_q <= IDLE;
                ISSUE: begin
                    gnt_q   <= onehot(owner_q);
                    state_q <= DONE;
                end
                DONE: begin
                    ptr_q   <= next_idx(owner_q);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            // A new winner from IDLE or DONE overrides the default transition.
            if (capture) begin
                owner_q  <= pick_idx;
                adr_q    <= pick_adr;
                wdata_q  <= pick_wdata;
                mem_we_q <= bus.we[pick_idx];
                state_q  <= ISSUE;
            end
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.rdata   = bus.mem_rd;
    assign bus.mem_adr = adr_q;
    assign bus.mem_wd  = wdata_q;
    assign bus.mem_we  = mem_we_q & ~reset;
    assign state_o     = state_q;
    assign ptr_o       = ptr_q;

endmodule
